// File: rtl/bsg_manycore_io_reset_seq.sv
// rtl/bsg_manycore_io_reset_seq.sv - staggered multi-channel reset sequencer with done tracking and timeout
//
// Purpose: holds every channel (pod) in reset for hold_cycles_p cycles. It then releases
// the channels one at a time, release_stagger_p cycles apart, and collects a sticky done
// flag from each released channel. Once all flags are seen and reset_depth_p settle cycles
// have passed, it releases the host and starts a free-running cycle counter. If the flags
// do not all arrive within timeout_cycles_p cycles, it parks in a sticky error state.
//
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   sw_reset_i      synchronous restart, highest priority
//   tag_done_i      per-channel done level, only sampled once the channel is released
//   chan_reset_o    per-channel core reset (active-high)
//   host_reset_o    host/IO reset, always ~ready_o
//   ready_o         all channels released, done and settled
//   error_o         sticky timeout flag
//   done_r_o        sticky per-channel done status
//   ctr_r_o         cycles since ready_o rose
//
// Optional: define BSG_MANYCORE_IO_RESET_SEQ_TRACE_EN to print state transitions and
// per-channel done-capture latency (simulation only).
module bsg_manycore_io_reset_seq #(
    parameter int num_channels_p    = 4,
    parameter int hold_cycles_p     = 4,
    parameter int release_stagger_p = 2,
    parameter int reset_depth_p     = 3,
    parameter int timeout_cycles_p  = 1024,
    parameter int ctr_width_p       = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      sw_reset_i,
    input  logic [num_channels_p-1:0] tag_done_i,
    output logic [num_channels_p-1:0] chan_reset_o,
    output logic                      host_reset_o,
    output logic                      ready_o,
    output logic                      error_o,
    output logic [num_channels_p-1:0] done_r_o,
    output logic [ctr_width_p-1:0]    ctr_r_o
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_RELEASE,
        S_WAIT_DONE,
        S_SETTLE,
        S_READY,
        S_ERROR
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               hold_cnt_q, hold_cnt_d;
    logic [31:0]               stag_cnt_q, stag_cnt_d;
    logic [31:0]               rel_idx_q, rel_idx_d;
    logic [31:0]               tmo_cnt_q, tmo_cnt_d;
    logic [31:0]               settle_cnt_q, settle_cnt_d;
    logic [num_channels_p-1:0] chan_reset_q, chan_reset_d;
    logic [num_channels_p-1:0] done_r_q, done_r_d;
    logic                      ready_q, ready_d;
    logic                      host_reset_q, host_reset_d;
    logic                      error_q, error_d;
    logic [ctr_width_p-1:0]    ctr_q, ctr_d;
    logic                      all_done_q, all_done_d;

    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        stag_cnt_d   = stag_cnt_q;
        rel_idx_d    = rel_idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        settle_cnt_d = settle_cnt_q;
        chan_reset_d = chan_reset_q;
        done_r_d     = done_r_q;
        ready_d      = ready_q;
        error_d      = error_q;
        ctr_d        = ctr_q;

        // A done level only counts once its channel is out of reset.
        if (state_q != S_READY) begin
            done_r_d = done_r_q | (tag_done_i & ~chan_reset_q);
        end
        all_done_q = &done_r_q;
        all_done_d = &done_r_d;

        case (state_q)
            S_HOLD: begin
                if (hold_cnt_q == 32'(hold_cycles_p - 1)) begin
                    chan_reset_d[0] = 1'b0;
                    rel_idx_d       = 32'd1;
                    stag_cnt_d      = '0;
                    state_d         = S_RELEASE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 32'd1;
                end
            end
            S_RELEASE: begin
                // rel_idx_q is the next channel to release.
                if (rel_idx_q == 32'(num_channels_p)) begin
                    tmo_cnt_d = '0;
                    state_d   = S_WAIT_DONE;
                end else if (stag_cnt_q + 32'd1 == 32'(release_stagger_p)) begin
                    for (int c = 0; c < num_channels_p; c++) begin
                        if (rel_idx_q == 32'(c)) chan_reset_d[c] = 1'b0;
                    end
                    rel_idx_d  = rel_idx_q + 32'd1;
                    stag_cnt_d = '0;
                end else begin
                    stag_cnt_d = stag_cnt_q + 32'd1;
                end
            end
            S_WAIT_DONE: begin
                // The settle count runs from the capture edge. A flag captured on
                // the entry edge has already used one settle cycle.
                if (all_done_q) begin
                    if (reset_depth_p == 1) begin
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end else begin
                        settle_cnt_d = 32'd1;
                        state_d      = S_SETTLE;
                    end
                end else if (all_done_d) begin
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 32'd1;
                    if (timeout_cycles_p != 0 && tmo_cnt_d == 32'(timeout_cycles_p)) begin
                        error_d = 1'b1;
                        state_d = S_ERROR;
                    end
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q + 32'd1 == 32'(reset_depth_p)) begin
                    ready_d = 1'b1;
                    state_d = S_READY;
                end else begin
                    settle_cnt_d = settle_cnt_q + 32'd1;
                end
            end
            S_READY: begin
                ctr_d = ctr_q + ctr_width_p'(1);
            end
            default: begin
                // S_ERROR: parked until restart.
            end
        endcase

        host_reset_d = ~ready_d;

        if (sw_reset_i) begin
            state_d      = S_HOLD;
            hold_cnt_d   = '0;
            stag_cnt_d   = '0;
            rel_idx_d    = '0;
            tmo_cnt_d    = '0;
            settle_cnt_d = '0;
            chan_reset_d = '1;
            done_r_d     = '0;
            ready_d      = 1'b0;
            host_reset_d = 1'b1;
            error_d      = 1'b0;
            ctr_d        = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= S_HOLD;
            hold_cnt_q   <= '0;
            stag_cnt_q   <= '0;
            rel_idx_q    <= '0;
            tmo_cnt_q    <= '0;
            settle_cnt_q <= '0;
            chan_reset_q <= '1;
            done_r_q     <= '0;
            ready_q      <= 1'b0;
            host_reset_q <= 1'b1;
            error_q      <= 1'b0;
            ctr_q        <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            stag_cnt_q   <= stag_cnt_d;
            rel_idx_q    <= rel_idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            chan_reset_q <= chan_reset_d;
            done_r_q     <= done_r_d;
            ready_q      <= ready_d;
            host_reset_q <= host_reset_d;
            error_q      <= error_d;
            ctr_q        <= ctr_d;
        end
    end

    assign chan_reset_o = chan_reset_q;
    assign host_reset_o = host_reset_q;
    assign ready_o      = ready_q;
    assign error_o      = error_q;
    assign done_r_o     = done_r_q;
    assign ctr_r_o      = ctr_q;

`ifdef BSG_MANYCORE_IO_RESET_SEQ_TRACE_EN
    // lat_q[c] counts edges since channel c left reset.
    logic [31:0] lat_q [num_channels_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int c = 0; c < num_channels_p; c++) lat_q[c] <= '0;
        end else begin
            if (state_d != state_q) begin
                $display("%0t: reset_seq %s -> %s", $time, state_q.name(), state_d.name());
            end
            for (int c = 0; c < num_channels_p; c++) begin
                if (sw_reset_i || chan_reset_q[c]) lat_q[c] <= '0;
                else lat_q[c] <= lat_q[c] + 32'd1;
                if (!sw_reset_i && done_r_d[c] && !done_r_q[c]) begin
                    $display("%0t: reset_seq ch %0d done, latency %0d", $time, c, lat_q[c] + 32'd1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_io_reset_seq.sv
// tb/tb_bsg_manycore_io_reset_seq.sv - self-checking bench for bsg_manycore_io_reset_seq
module tb_bsg_manycore_io_reset_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance a: defaults. b: timeout 16. c: one channel, hold 1, depth 1, 4-bit counter.
    logic [3:0]  tag_a, tag_b;
    logic [0:0]  tag_c;
    logic        sw_a, sw_b, sw_c;
    logic [3:0]  chan_a, chan_b, done_a, done_b;
    logic [0:0]  chan_c, done_c;
    logic        host_a, host_b, host_c, rdy_a, rdy_b, rdy_c, err_a, err_b, err_c;
    logic [63:0] ctr_a, ctr_b;
    logic [3:0]  ctr_c;

    bsg_manycore_io_reset_seq dut_a (
        .clk_i(clk), .reset_i(rst), .sw_reset_i(sw_a), .tag_done_i(tag_a),
        .chan_reset_o(chan_a), .host_reset_o(host_a), .ready_o(rdy_a),
        .error_o(err_a), .done_r_o(done_a), .ctr_r_o(ctr_a));

    bsg_manycore_io_reset_seq #(.timeout_cycles_p(16)) dut_b (
        .clk_i(clk), .reset_i(rst), .sw_reset_i(sw_b), .tag_done_i(tag_b),
        .chan_reset_o(chan_b), .host_reset_o(host_b), .ready_o(rdy_b),
        .error_o(err_b), .done_r_o(done_b), .ctr_r_o(ctr_b));

    bsg_manycore_io_reset_seq #(.num_channels_p(1), .hold_cycles_p(1), .reset_depth_p(1),
                                .ctr_width_p(4)) dut_c (
        .clk_i(clk), .reset_i(rst), .sw_reset_i(sw_c), .tag_done_i(tag_c),
        .chan_reset_o(chan_c), .host_reset_o(host_c), .ready_o(rdy_c),
        .error_o(err_c), .done_r_o(done_c), .ctr_r_o(ctr_c));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cycle index since (re)start and the cycle each channel's done was captured.
    int p_n [3] = '{4, 4, 1};
    int p_h [3] = '{4, 4, 1};
    int p_s [3] = '{2, 2, 2};
    int p_d [3] = '{3, 3, 1};
    int p_t [3] = '{1024, 16, 1024};
    int p_w [3] = '{64, 64, 4};
    int mk  [3];
    int cap [3][4];

    function automatic int rel_cyc(int i, int c);
        return p_h[i] + c * p_s[i];
    endfunction

    function automatic int wait_entry(int i);
        return p_h[i] + (p_n[i] - 1) * p_s[i] + 1;
    endfunction

    function automatic int ready_at(int i);
        int m = 0;
        for (int c = 0; c < p_n[i]; c++) begin
            if (cap[i][c] < 0) return -1;
            if (cap[i][c] > m) m = cap[i][c];
        end
        if (p_t[i] != 0 && m > wait_entry(i) + p_t[i]) return -1;
        return m + p_d[i];
    endfunction

    task automatic model_restart(int i);
        mk[i] = 0;
        for (int c = 0; c < 4; c++) cap[i][c] = -1;
    endtask

    task automatic model_edge(int i, logic [3:0] tag, logic sw);
        if (sw) begin
            model_restart(i);
        end else begin
            mk[i] = mk[i] + 1;
            for (int c = 0; c < p_n[i]; c++) begin
                if (cap[i][c] < 0 && mk[i] > rel_cyc(i, c) && tag[c]) cap[i][c] = mk[i];
            end
        end
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_inst(int i, logic [3:0] chan, logic host, logic rdy, logic err,
                              logic [3:0] done, logic [63:0] ctr);
        logic [3:0]  e_chan, e_done;
        logic [63:0] e_ctr, mask;
        logic        e_rdy, e_err;
        int          ra;
        string       id;
        id = $sformatf("inst%0d k=%0d", i, mk[i]);
        ra = ready_at(i);
        e_chan = '0;
        e_done = '0;
        for (int c = 0; c < p_n[i]; c++) begin
            e_chan[c] = (mk[i] < rel_cyc(i, c));
            e_done[c] = (cap[i][c] >= 0);
        end
        e_rdy = (ra >= 0) && (mk[i] >= ra);
        e_err = (p_t[i] != 0) && (mk[i] >= wait_entry(i) + p_t[i]) && (ra < 0);
        mask  = (p_w[i] >= 64) ? '1 : ((64'd1 << p_w[i]) - 64'd1);
        e_ctr = e_rdy ? (64'(mk[i] - ra) & mask) : 64'd0;
        chk({id, " chan_reset"}, 64'(chan), 64'(e_chan));
        chk({id, " done_r"},     64'(done), 64'(e_done));
        chk({id, " ready"},      64'(rdy),  64'(e_rdy));
        chk({id, " host_reset"}, 64'(host), 64'(!e_rdy));
        chk({id, " error"},      64'(err),  64'(e_err));
        chk({id, " ctr"},        ctr,       e_ctr);
    endtask

    task automatic check_all();
        check_inst(0, chan_a, host_a, rdy_a, err_a, done_a, ctr_a);
        check_inst(1, chan_b, host_b, rdy_b, err_b, done_b, ctr_b);
        check_inst(2, {3'b0, chan_c}, host_c, rdy_c, err_c, {3'b0, done_c}, {60'd0, ctr_c});
    endtask

    // One clock: model follows the inputs sampled at the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge(0, tag_a, sw_a);
        model_edge(1, tag_b, sw_b);
        model_edge(2, {3'b0, tag_c}, sw_c);
        @(negedge clk);
        check_all();
    endtask

    typedef struct {
        int          cyc;
        logic [3:0]  chan;
        logic [3:0]  done;
        logic        rdy;
        logic [63:0] ctr;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{cyc: 3,  chan: 4'b1111, done: 4'b0000, rdy: 1'b0, ctr: 64'd0};
        tbl[1]  = '{cyc: 4,  chan: 4'b1110, done: 4'b0000, rdy: 1'b0, ctr: 64'd0};
        tbl[2]  = '{cyc: 5,  chan: 4'b1110, done: 4'b0001, rdy: 1'b0, ctr: 64'd0};
        tbl[3]  = '{cyc: 6,  chan: 4'b1100, done: 4'b0001, rdy: 1'b0, ctr: 64'd0};
        tbl[4]  = '{cyc: 7,  chan: 4'b1100, done: 4'b0011, rdy: 1'b0, ctr: 64'd0};
        tbl[5]  = '{cyc: 8,  chan: 4'b1000, done: 4'b0011, rdy: 1'b0, ctr: 64'd0};
        tbl[6]  = '{cyc: 10, chan: 4'b0000, done: 4'b0111, rdy: 1'b0, ctr: 64'd0};
        tbl[7]  = '{cyc: 11, chan: 4'b0000, done: 4'b1111, rdy: 1'b0, ctr: 64'd0};
        tbl[8]  = '{cyc: 13, chan: 4'b0000, done: 4'b1111, rdy: 1'b0, ctr: 64'd0};
        tbl[9]  = '{cyc: 14, chan: 4'b0000, done: 4'b1111, rdy: 1'b1, ctr: 64'd0};
        tbl[10] = '{cyc: 15, chan: 4'b0000, done: 4'b1111, rdy: 1'b1, ctr: 64'd1};
        tbl[11] = '{cyc: 19, chan: 4'b0000, done: 4'b1111, rdy: 1'b1, ctr: 64'd5};

        rst   = 1'b1;
        sw_a  = 1'b0;
        sw_b  = 1'b0;
        sw_c  = 1'b0;
        tag_a = 4'hF;
        tag_b = 4'b1101;
        tag_c = 1'b1;
        for (int i = 0; i < 3; i++) model_restart(i);
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // Default sequence (table), timeout on b, single channel wrap on c.
        for (int cyc = 1; cyc <= 140; cyc++) begin
            tick();
            foreach (tbl[j]) begin
                if (tbl[j].cyc == cyc) begin
                    chk($sformatf("tbl cyc%0d chan", cyc), 64'(chan_a), 64'(tbl[j].chan));
                    chk($sformatf("tbl cyc%0d done", cyc), 64'(done_a), 64'(tbl[j].done));
                    chk($sformatf("tbl cyc%0d ready", cyc), 64'(rdy_a), 64'(tbl[j].rdy));
                    chk($sformatf("tbl cyc%0d host", cyc), 64'(host_a), 64'(!tbl[j].rdy));
                    chk($sformatf("tbl cyc%0d ctr", cyc), ctr_a, tbl[j].ctr);
                end
            end
            if (cyc == 26) chk("b error before timeout", 64'(err_b), 64'd0);
            if (cyc == 27) chk("b error at timeout", 64'(err_b), 64'd1);
            if (cyc == 130) chk("b error sticky", 64'(err_b), 64'd1);
            if (cyc == 130) chk("b host held in error", 64'(host_b), 64'd1);
            if (cyc == 1) chk("c chan released", 64'(chan_c), 64'd0);
            if (cyc == 2) chk("c not ready", 64'(rdy_c), 64'd0);
            if (cyc == 3) chk("c ready", 64'(rdy_c), 64'd1);
            if (cyc == 18) chk("c ctr 15", 64'(ctr_c), 64'd15);
            if (cyc == 19) chk("c ctr wrap", 64'(ctr_c), 64'd0);
        end

        // Restart b out of ERROR with all flags set.
        sw_b  = 1'b1;
        tag_b = 4'hF;
        tick();
        sw_b = 1'b0;
        chk("b error cleared", 64'(err_b), 64'd0);
        chk("b done cleared", 64'(done_b), 64'd0);
        chk("b chans in reset", 64'(chan_b), 64'hF);
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 13) chk("b ready before restart+14", 64'(rdy_b), 64'd0);
            if (k == 14) chk("b ready restart+14", 64'(rdy_b), 64'd1);
        end

        // Done pulse on a channel still in reset is ignored.
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            tag_a = {1'b1, (k == 5) || (k >= 30), 2'b11};
            tick();
            if (k == 29) chk("a done2 ignored pulse", 64'(done_a[2]), 64'd0);
            if (k == 30) chk("a done2 captured", 64'(done_a[2]), 64'd1);
            if (k == 32) chk("a not ready at 32", 64'(rdy_a), 64'd0);
            if (k == 33) chk("a ready at 33", 64'(rdy_a), 64'd1);
        end

        // Asynchronous reset in the middle of RELEASE.
        sw_a  = 1'b1;
        tag_a = 4'hF;
        tick();
        sw_a = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        chk("a mid release chan", 64'(chan_a), 64'b1100);
        #2 rst = 1'b1;
        #1;
        chk("async chan_reset", 64'(chan_a), 64'hF);
        chk("async host_reset", 64'(host_a), 64'd1);
        chk("async b ready", 64'(rdy_b), 64'd0);
        for (int i = 0; i < 3; i++) model_restart(i);
        #1 rst = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (k == 13) chk("a post-reset not ready", 64'(rdy_a), 64'd0);
            if (k == 14) chk("a post-reset ready", 64'(rdy_a), 64'd1);
        end

        // Random inputs and restarts checked against the model every cycle.
        for (int n = 0; n < 900; n++) begin
            for (int c = 0; c < 4; c++) begin
                tag_a[c] = ($urandom_range(0, 5) == 0);
                tag_b[c] = ($urandom_range(0, 9) == 0);
            end
            tag_c = 1'($urandom_range(0, 3) == 0);
            sw_a  = ($urandom_range(0, 59) == 0);
            sw_b  = ($urandom_range(0, 79) == 0);
            sw_c  = ($urandom_range(0, 29) == 0);
            tick();
        end
        sw_a = 1'b0;
        sw_b = 1'b0;
        sw_c = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsg_manycore_io_reset_seq.md
Name: bsg_manycore_io_reset_seq

Overview:
- Multi-channel reset sequencer and done tracker for the host/IO complex of multi-pod manycore testbenches.
- Releases per-channel (per-pod) core resets in staggered order and collects each channel's tag-programming done flag.
- Holds host reset until all done flags are seen plus a settle delay; supervises the wait with a timeout.
- Provides a post-ready cycle counter for profilers. Generalises the single-channel done delay chain to N channels, with staggering, timeout and software restart.

Parameters:
- num_channels_p, 4: number of independent reset channels (pods); must be >=1.
- hold_cycles_p, 4: cycles in HOLD before channel 0 releases; must be >=1.
- release_stagger_p, 2: cycles between consecutive channel releases; must be >=1.
- reset_depth_p, 3: settle cycles after all done flags before ready; must be >=1.
- timeout_cycles_p, 1024: maximum cycles in WAIT_DONE; 0 disables the timeout.
- ctr_width_p, 64: width of the post-ready cycle counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- sw_reset_i  in  1  synchronous restart request; sequence restarts from HOLD.
- tag_done_i  in  num_channels_p  per-channel tag-programming done flag; level.
- chan_reset_o  out  num_channels_p  per-channel core reset, active-high.
- host_reset_o  out  1  host/IO endpoint reset, active-high; equals ~ready_o.
- ready_o  out  1  all channels released, done and settled.
- error_o  out  1  sticky timeout flag.
- done_r_o  out  num_channels_p  sticky per-channel done status.
- ctr_r_o  out  ctr_width_p  cycles elapsed since ready_o rose.

Behaviour:
- Reset values, asynchronous on reset_i:
  - chan_reset_o all 1s; host_reset_o=1; ready_o=0; error_o=0; done_r_o=0; ctr_r_o=0.
  - state=HOLD; internal counters=0.
- All outputs are registered; no combinational path from any input to any output.
- Timing reference: cycle 1 is the first rising edge with reset_i low.
- State HOLD:
  - Counts hold_cycles_p cycles, then goes to RELEASE.
- State RELEASE:
  - Channel c's reset deasserts at cycle hold_cycles_p + c*release_stagger_p.
  - After the last channel releases, go to WAIT_DONE on the next edge.
- Done tracking (all states):
  - done_r[c] sets on an edge where tag_done_i[c]=1 and chan_reset_o[c]=0.
  - tag_done_i[c] is ignored while the channel is in reset.
  - done_r is sticky until restart, even if tag_done_i drops.
- State WAIT_DONE:
  - When done_r is all 1s (including any set on the current edge), go to SETTLE.
  - Otherwise a timeout counter increments each cycle. Reaching timeout_cycles_p (if nonzero) goes to ERROR.
- State SETTLE:
  - Counts reset_depth_p cycles. ready_o=1 and host_reset_o=0 on the edge that ends the count; go to READY.
  - ready_o therefore rises reset_depth_p cycles after the edge on which the last done is captured.
- State READY:
  - ctr_r_o increments by 1 every cycle and wraps modulo 2^ctr_width_p.
  - tag_done_i changes are ignored.
- State ERROR:
  - error_o=1; host_reset_o stays 1; ready_o stays 0.
  - Channels remain released. Exit only via sw_reset_i or reset_i.
- Restart: sw_reset_i=1 on any edge, in any state, takes priority over all other transitions. Next cycle:
  - state=HOLD; all chan_reset_o=1; host_reset_o=1; ready_o=0.
  - done_r_o=0; ctr_r_o=0; error_o=0; all counters cleared.
  - Holding sw_reset_i high keeps the block in HOLD with the hold counter at 0.
- reset_i mid-operation: immediate asynchronous return to the reset values, regardless of state.
- num_channels_p=1: RELEASE lasts a single cycle; no stagger is applied.

Optional Feature:
- Macro: BSG_MANYCORE_IO_RESET_SEQ_TRACE_EN.
- When defined: the nonsynth block prints one $display line per state transition, giving time, old state and new state.
  - On each done capture it also prints the channel index and the capture latency: cycles from that channel's release to done capture, from a per-channel latency counter.
- When undefined: no display statements and no latency counters. Port list and cycle behaviour are identical.

Test Plan:
- Defaults, tag_done_i all 1s from cycle 0 -> chan_reset_o deasserts in order ch0@4, ch1@6, ch2@8, ch3@10; done_r_o=4'b1111 at cycle 11; ready_o=1 and host_reset_o=0 at cycle 14; ctr_r_o=5 at cycle 19.
- tag_done_i[2] pulsed at cycle 5, while ch2 is still in reset, then held 0 until cycle 30 -> the cycle-5 pulse is ignored; done_r_o[2] sets at 30; ready_o rises at 33.
- timeout_cycles_p=16, tag_done_i[1] never asserted -> error_o=1 16 cycles after WAIT_DONE entry; host_reset_o stays 1; ready_o stays 0; error holds for 100+ cycles.
- From ERROR, sw_reset_i pulsed 1 cycle, then all done flags 1 -> error_o, done_r_o and ctr_r_o clear; channels re-released with the same stagger; ready_o rises 14 cycles after the pulse.
- reset_i asserted asynchronously mid-RELEASE (between edges) -> chan_reset_o=4'b1111 and host_reset_o=1 immediately, before the next edge; full sequence repeats after deassertion.
- num_channels_p=1, hold_cycles_p=1, reset_depth_p=1, done high -> chan_reset_o=0 at cycle 1; ready_o=1 at cycle 3; ctr_r_o wraps correctly with ctr_width_p=4 (0 after 16 READY cycles).
